// File: rtl/rom_dump_sequencer.sv
// rtl/rom_dump_sequencer.sv - full-chip IP3601/IP3604 PROM dump walker with valid/ready word output
module rom_dump_sequencer #(
    parameter int SETTLE_CYCLES = 50,  // clocks address/selects are held before sampling, >= 1
    parameter int COUNTER_WIDTH = 8    // settle counter width, 2**COUNTER_WIDTH > SETTLE_CYCLES
) (
    input  logic       clk,                    // all state changes on rising edge
    input  logic       reset,                  // synchronous, active-high
    input  logic       start,                  // begin a dump, honoured only while idle
    input  logic       abort,                  // drop a dump in progress
    input  logic       chip_type,              // 0 = IP3601 (256x4), 1 = IP3604 (512x8)
    input  logic [7:0] chip_data_port,         // PROM data bus
    output logic [8:0] chip_address_port,      // PROM address
    output logic [1:0] ip3601_selection_port,  // IP3601 selects, active-low
    output logic [3:0] ip3604_selection_port,  // IP3604 selects, active-low
    output logic [8:0] out_address,            // address of the presented word
    output logic [7:0] out_data,               // presented word
    output logic       out_valid,              // stream valid
    input  logic       out_ready,              // stream ready
    output logic       busy,                   // high outside IDLE
    output logic       done                    // one-cycle pulse when the dump completes
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HANDSHAKE,
        S_DONE
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] SETTLE_LAST = COUNTER_WIDTH'(SETTLE_CYCLES - 1);

    state_t                   state;
    logic                     chip_q;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [8:0]               last_addr;

    // Last address depends only on the chip type latched at start, never the live input.
    always_comb begin
        last_addr = chip_q ? 9'd511 : 9'd255;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            chip_q                <= 1'b0;
            counter               <= '0;
            chip_address_port     <= 9'd0;
            ip3601_selection_port <= 2'b11;
            ip3604_selection_port <= 4'hF;
            out_address           <= 9'd0;
            out_data              <= 8'd0;
            out_valid             <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                // start together with abort leaves the sequencer idle
                if (start && !abort) begin
                    chip_q            <= chip_type;
                    chip_address_port <= 9'd0;
                    counter           <= '0;
                    busy              <= 1'b1;
                    state             <= S_SETTLE;
                    if (chip_type) begin
                        ip3604_selection_port <= 4'h0;
                    end else begin
                        ip3601_selection_port <= 2'b00;
                    end
                end
            end else if (abort) begin
                // Abort wins over a coincident transfer; that word is already with the consumer.
                state                 <= S_IDLE;
                busy                  <= 1'b0;
                out_valid             <= 1'b0;
                counter               <= '0;
                chip_address_port     <= 9'd0;
                ip3601_selection_port <= 2'b11;
                ip3604_selection_port <= 4'hF;
            end else begin
                case (state)
                    S_SETTLE: begin
                        counter <= counter + 1'b1;
                        if (counter == SETTLE_LAST) begin
                            state <= S_SAMPLE;
                        end
                    end
                    S_SAMPLE: begin
                        // IP3601 is a 4-bit part; its upper data lines are meaningless
                        out_data    <= chip_q ? chip_data_port : {4'h0, chip_data_port[3:0]};
                        out_address <= chip_address_port;
                        out_valid   <= 1'b1;
                        state       <= S_HANDSHAKE;
                    end
                    S_HANDSHAKE: begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            if (chip_address_port == last_addr) begin
                                state                 <= S_DONE;
                                done                  <= 1'b1;
                                ip3601_selection_port <= 2'b11;
                                ip3604_selection_port <= 4'hF;
                            end else begin
                                chip_address_port <= chip_address_port + 9'd1;
                                counter           <= '0;
                                state             <= S_SETTLE;
                            end
                        end
                    end
                    S_DONE: begin
                        chip_address_port <= 9'd0;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
